// File: rtl/ntsc_fb_pkg.sv
// Frame-buffer definitions shared by the NTSC writer and the XGA reader:
// ZBT word address packing and RGB666 pixel layout.
package ntsc_fb_pkg;

  localparam int unsigned Y_W     = 9;
  localparam int unsigned XW_W    = 9;
  localparam int unsigned ADDR_W  = Y_W + 1 + XW_W;
  localparam int unsigned PIX_W   = 18;
  localparam int unsigned WORD_W  = 2 * PIX_W;
  localparam int unsigned CH_W    = 6;
  localparam int unsigned R_OFS   = 12;
  localparam int unsigned G_OFS   = 6;
  localparam int unsigned B_OFS   = 0;
  localparam int unsigned H_TOTAL = 1344;
  localparam int unsigned V_TOTAL = 768;

  typedef struct packed {
    logic [Y_W-1:0]  y;
    logic            field;
    logic [XW_W-1:0] xw;
  } fb_addr_t;

  // One ZBT word holds the pixel pair (2*xw, 2*xw+1) of row y in the given field.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [Y_W-1:0] y,
                                                input logic field,
                                                input logic [XW_W-1:0] xw);
    fb_addr_t a;
    a.y     = y;
    a.field = field;
    a.xw    = xw;
    return a;
  endfunction

  function automatic logic [PIX_W-1:0] rgb_pack(input logic [CH_W-1:0] r,
                                                input logic [CH_W-1:0] g,
                                                input logic [CH_W-1:0] b);
    logic [PIX_W-1:0] p;
    p = '0;
    p[R_OFS +: CH_W] = r;
    p[G_OFS +: CH_W] = g;
    p[B_OFS +: CH_W] = b;
    return p;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipe with a configurable reset value.
module delay_line #(
  parameter int unsigned W       = 1,
  parameter int unsigned N       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [N-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[N-1];

endmodule

// File: rtl/zbt_pixel_reader.sv
// ZBT frame-buffer read side: raster-driven word reads on even clocks,
// unpacked to RGB666 and aligned with the delayed XGA timing signals.
module zbt_pixel_reader
  import ntsc_fb_pkg::*;
#(
  parameter int unsigned IMG_W   = 720,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned ZBT_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic              mode,
  input  logic [WORD_W-1:0] vr_data,
  output logic [ADDR_W-1:0] vr_addr,
  output logic              vr_rd,
  output logic              wr_slot,
  output logic [PIX_W-1:0]  pixel,
  output logic              hsync_d,
  output logic              vsync_d,
  output logic              blank_d
);

  localparam logic [0:0]  ST_SYNC = 1'b0;
  localparam logic [0:0]  ST_RUN  = 1'b1;
  localparam int unsigned TIM_LAT = 4;
  localparam int unsigned VLD_LAT = ZBT_LAT + 1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_mode_q;
  logic              w_frame_start;
  logic              w_out_of_range;
  logic              w_in_window;
  logic              w_running;
  logic              w_pix_vld;
  logic              w_issue;
  logic              w_mode_eff;
  logic              w_field;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_vld_pipe;
  logic              w_vld_d;
  logic              w_odd_d;
  logic [2:0]        w_tim_d;
  logic [PIX_W-1:0]  r_word_lo;

  assign w_frame_start  = (hcount == 11'd0) && (vcount == 10'd0);
  assign w_out_of_range = (hcount >= 11'(H_TOTAL)) || (vcount >= 10'(V_TOTAL));
  assign w_in_window    = (hcount < 11'(IMG_W)) && (vcount < 10'(IMG_H));

  // The frame-start cycle already reads with the freshly sampled mode.
  assign w_mode_eff = w_frame_start ? mode : r_mode_q;
  assign w_field    = w_mode_eff ? 1'b0 : vcount[0];
  assign w_addr     = fb_addr(vcount[9:1], w_field, hcount[9:1]);
  assign w_pix_vld  = w_running && w_in_window;
  assign w_issue    = w_pix_vld && !hcount[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_SYNC;
      r_mode_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_frame_start) r_mode_q <= mode;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_running   = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_frame_start) begin
          w_state_nxt = ST_RUN;
          w_running   = 1'b1;
        end
      end
      ST_RUN: begin
        w_running = 1'b1;
        if (w_out_of_range) w_state_nxt = ST_SYNC;
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // Even clocks inside the window belong to the reader; all others to the writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vr_addr <= '0;
      vr_rd   <= 1'b0;
      wr_slot <= 1'b0;
    end else begin
      vr_rd   <= w_issue;
      wr_slot <= !w_issue;
      if (w_issue) vr_addr <= w_addr;
    end
  end

  delay_line #(
    .W       (2),
    .N       (VLD_LAT),
    .RST_VAL (2'b00)
  ) u_vld_pipe (
    .clk   (clk),
    .reset (reset),
    .i_d   ({w_pix_vld, hcount[0]}),
    .o_q   (w_vld_pipe)
  );

  assign w_vld_d = w_vld_pipe[1];
  assign w_odd_d = w_vld_pipe[0];

  delay_line #(
    .W       (3),
    .N       (TIM_LAT),
    .RST_VAL (3'b111)
  ) u_tim_pipe (
    .clk   (clk),
    .reset (reset),
    .i_d   ({hsync, vsync, blank}),
    .o_q   (w_tim_d)
  );

  assign {hsync_d, vsync_d, blank_d} = w_tim_d;

  // Upper half goes straight out as the word arrives; lower half is parked for the odd pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel     <= '0;
      r_word_lo <= '0;
    end else if (w_vld_d && !w_odd_d) begin
      pixel     <= vr_data[WORD_W-1:PIX_W];
      r_word_lo <= vr_data[PIX_W-1:0];
    end else if (w_vld_d) begin
      pixel <= r_word_lo;
    end else begin
      pixel <= '0;
    end
  end

endmodule

// File: tb/tb_zbt_pixel_reader.sv
// Bench for zbt_pixel_reader: ZBT memory model, per-cycle reference model and
// directed raster segments with hand-computed expectations.
module tb_zbt_pixel_reader;

  localparam int IMG_W = 720;
  localparam int IMG_H = 480;
  localparam int HN    = 4096;

  typedef struct packed {
    logic        rst;
    logic        issue;
    logic [18:0] addr;
    logic [17:0] pix;
    logic        hs;
    logic        vs;
    logic        bl;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank, mode;
  logic [35:0] vr_data;
  logic [18:0] vr_addr;
  logic        vr_rd, wr_slot;
  logic [17:0] pixel;
  logic        hsync_d, vsync_d, blank_d;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  ent_t hist [HN];

  logic [18:0] q1 = '0;
  logic [18:0] q2 = '0;

  zbt_pixel_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ZBT_LAT(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .hcount  (hcount),
    .vcount  (vcount),
    .hsync   (hsync),
    .vsync   (vsync),
    .blank   (blank),
    .mode    (mode),
    .vr_data (vr_data),
    .vr_addr (vr_addr),
    .vr_rd   (vr_rd),
    .wr_slot (wr_slot),
    .pixel   (pixel),
    .hsync_d (hsync_d),
    .vsync_d (vsync_d),
    .blank_d (blank_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [35:0] mem(input logic [18:0] a);
    if (a == 19'h01607) return {18'h3F000, 18'h00FC0};
    return {a[17:0] ^ 18'h15555, a[8:0], a[18:10]};
  endfunction

  // Word address from raster position: row pair, field, pixel pair.
  function automatic logic [18:0] mk_addr(input int vc, input int x, input logic m);
    int f;
    f = m ? 0 : vc % 2;
    return 19'((vc / 2) * 1024 + f * 512 + x / 2);
  endfunction

  // ZBT: address seen in cycle k returns data in cycle k+2.
  always @(posedge clk) begin
    q1 <= vr_addr;
    q2 <= q1;
  end
  assign vr_data = mem(q2);

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  // Reference model: one entry per sampling edge.
  initial begin : model
    logic m_run, m_mode, fs, oor, run_now;
    logic [18:0] m_addr, a;
    logic [35:0] w;
    ent_t e;
    m_run = 1'b0; m_mode = 1'b0; m_addr = '0;
    forever begin
      @(posedge clk);
      cyc++;
      e = '0;
      if (reset) begin
        e.rst = 1'b1;
        m_run = 1'b0; m_mode = 1'b0; m_addr = '0;
      end else begin
        fs  = (hcount == 0) && (vcount == 0);
        oor = (hcount >= 1344) || (vcount >= 768);
        if (fs) m_mode = mode;
        run_now = m_run || fs;
        e.hs = hsync; e.vs = vsync; e.bl = blank;
        if (run_now && int'(hcount) < IMG_W && int'(vcount) < IMG_H) begin
          a = mk_addr(int'(vcount), int'(hcount) - int'(hcount) % 2, m_mode);
          w = mem(a);
          e.pix = hcount[0] ? w[17:0] : w[35:18];
          if (!hcount[0]) begin
            e.issue = 1'b1;
            m_addr  = a;
          end
        end
        e.addr = m_addr;
        m_run  = fs ? 1'b1 : (oor ? 1'b0 : m_run);
      end
      hist[cyc % HN] = e;
    end
  end

  // Compare every cycle on the falling edge.
  initial begin : compare
    ent_t cur, src;
    logic clr, e_rd, e_slot;
    logic [18:0] e_addr;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        cur = hist[cyc % HN];
        if (reset || cur.rst) begin
          e_rd = 1'b0; e_slot = 1'b0; e_addr = '0;
        end else begin
          e_rd = cur.issue; e_slot = !cur.issue; e_addr = cur.addr;
        end
        clr = reset || (cyc < 4);
        if (!clr) for (int k = 0; k < 4; k++) if (hist[(cyc - k) % HN].rst) clr = 1'b1;
        src = hist[(cyc + HN - 3) % HN];
        chk("vr_rd", 36'(vr_rd), 36'(e_rd));
        chk("wr_slot", 36'(wr_slot), 36'(e_slot));
        chk("vr_addr", 36'(vr_addr), 36'(e_addr));
        chk("pixel", 36'(pixel), clr ? 36'(0) : 36'(src.pix));
        chk("sync_blank", 36'({hsync_d, vsync_d, blank_d}),
            clr ? 36'(3'b111) : 36'({src.hs, src.vs, src.bl}));
      end
    end
  end

  task automatic set_in(input int hc, input int vc);
    hcount = 11'(hc);
    vcount = 10'(vc);
    hsync  = ~hcount[2];
    vsync  = ~(vcount[0] ^ hcount[3]);
    blank  = hcount[1];
  endtask

  task automatic drive(input int hc, input int vc);
    set_in(hc, vc);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    mode  = 1'b0;
    set_in(100, 5);
    repeat (3) drive(100, 5);
    chk("rst_rd", 36'(vr_rd), 36'(0));
    chk("rst_slot", 36'(wr_slot), 36'(0));
    chk("rst_hs", 36'(hsync_d), 36'(1));
    reset = 1'b0;

    // SYNC before the first frame start
    for (int h = 100; h < 110; h++) drive(h, 5);
    chk("sync_rd", 36'(vr_rd), 36'(0));
    chk("sync_slot", 36'(wr_slot), 36'(1));
    chk("sync_pix", 36'(pixel), 36'(0));

    // frame start, weave mode
    drive(0, 0);
    chk("fs_rd", 36'(vr_rd), 36'(1));
    chk("fs_addr", 36'(vr_addr), 36'(0));
    for (int h = 1; h < 8; h++) begin
      drive(h, 0);
      if (h == 3) chk("fs_pix_hi", 36'(pixel), 36'(18'h15555));
      if (h == 4) chk("fs_pix_lo", 36'(pixel), 36'(0));
    end

    drive(14, 11);
    chk("a1607_rd", 36'(vr_rd), 36'(1));
    chk("a1607", 36'(vr_addr), 36'(19'h01607));
    drive(15, 11);
    chk("odd_rd", 36'(vr_rd), 36'(0));
    chk("odd_slot", 36'(wr_slot), 36'(1));
    drive(16, 11);
    drive(17, 11);
    chk("pix_hi", 36'(pixel), 36'(18'h3F000));
    drive(18, 11);
    chk("pix_lo", 36'(pixel), 36'(18'h00FC0));
    drive(19, 11);

    // full active line plus right edge
    for (int h = 0; h <= IMG_W + 8; h++) begin
      drive(h, 12);
      if (h == IMG_W - 2) begin
        chk("last_rd", 36'(vr_rd), 36'(1));
        chk("last_addr", 36'(vr_addr), 36'(19'h01967));
      end
      if (h == IMG_W) begin
        chk("edge_rd", 36'(vr_rd), 36'(0));
        chk("edge_slot", 36'(wr_slot), 36'(1));
      end
      if (h == IMG_W + 3) chk("edge_pix", 36'(pixel), 36'(0));
    end

    // below the image
    for (int h = 0; h < 6; h++) drive(h, IMG_H);
    chk("vbot_rd", 36'(vr_rd), 36'(0));
    chk("vbot_slot", 36'(wr_slot), 36'(1));
    chk("vbot_pix", 36'(pixel), 36'(0));

    // out-of-range timing drops back to SYNC
    drive(1344, IMG_H);
    for (int h = 0; h < 6; h++) begin
      drive(h, 12);
      if (h == 0) chk("oor_rd", 36'(vr_rd), 36'(0));
    end
    chk("oor_pix", 36'(pixel), 36'(0));

    // line-double mode, mid-frame change ignored
    mode = 1'b1;
    drive(0, 0);
    for (int h = 1; h < 4; h++) drive(h, 0);
    drive(14, 11);
    chk("m1_addr", 36'(vr_addr), 36'(19'h01407));
    drive(15, 11);
    mode = 1'b0;
    drive(14, 11);
    chk("m1_hold", 36'(vr_addr), 36'(19'h01407));
    for (int h = 15; h < 20; h++) drive(h, 11);
    drive(0, 0);
    drive(1, 0);
    drive(14, 11);
    chk("m0_addr", 36'(vr_addr), 36'(19'h01607));
    for (int h = 15; h < 20; h++) drive(h, 11);

    // reset in the middle of a line
    for (int h = 290; h < 300; h++) drive(h, 200);
    set_in(300, 200);
    #2 reset = 1'b1;
    #1;
    chk("mid_rd", 36'(vr_rd), 36'(0));
    chk("mid_slot", 36'(wr_slot), 36'(0));
    chk("mid_addr", 36'(vr_addr), 36'(0));
    chk("mid_pix", 36'(pixel), 36'(0));
    chk("mid_sync", 36'({hsync_d, vsync_d, blank_d}), 36'(3'b111));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int h = 302; h < 310; h++) drive(h, 200);
    chk("post_rd", 36'(vr_rd), 36'(0));
    chk("post_slot", 36'(wr_slot), 36'(1));
    chk("post_pix", 36'(pixel), 36'(0));
    drive(0, 0);
    chk("refs_rd", 36'(vr_rd), 36'(1));
    for (int h = 1; h < 8; h++) drive(h, 0);
    for (int i = 0; i < 6; i++) drive(700, 1);

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
